// File: rtl/axi_bridge_ip_rx_pkg.sv
// axi_bridge_ip_rx_pkg: shared types, sizing helpers and the packed RX FIFO word
// layout used by the RX deserializer, the RX FIFO and the AXI master logic.
package axi_bridge_ip_rx_pkg;

   // Frame tracking state of the deserializer
   typedef enum logic [0:0] {
      RX_IDLE  = 1'b0,
      RX_ACCUM = 1'b1
   } rx_state_e;

   // Number of link segments per AXI beat
   function automatic int unsigned rx_segs(input int unsigned data_w, input int unsigned if_w);
      return data_w / if_w;
   endfunction

   // Lane counter width, never narrower than one bit
   function automatic int unsigned rx_seg_idx_w(input int unsigned segs);
      return (segs > 32'd1) ? $clog2(segs) : 32'd1;
   endfunction

   // Width of the packed FIFO word {last, user, keep, data}
   function automatic int unsigned rx_word_w(input int unsigned data_w, input int unsigned tuser_w);
      return data_w + (data_w / 32'd8) + tuser_w + 32'd1;
   endfunction

   // Field offsets inside the packed FIFO word (data sits at the LSB)
   function automatic int unsigned rx_data_off();
      return 32'd0;
   endfunction

   function automatic int unsigned rx_keep_off(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned rx_user_off(input int unsigned data_w);
      return data_w + (data_w / 32'd8);
   endfunction

   function automatic int unsigned rx_last_off(input int unsigned data_w, input int unsigned tuser_w);
      return data_w + (data_w / 32'd8) + tuser_w;
   endfunction

endpackage

// File: rtl/axi_bridge_ip_rx_des_beat_assemble.sv
// axi_bridge_ip_rx_des_beat_assemble: segment accumulator. Writes each accepted
// segment into lane seg_idx, reports beat completion (last lane or eop) and hands
// the completed beat image, with unfilled lanes zeroed, to the output register.
module axi_bridge_ip_rx_des_beat_assemble
   import axi_bridge_ip_rx_pkg::*;
#(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned IF_W   = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  wr_i,
   input  logic                  start_i,
   input  logic                  eop_i,
   input  logic [IF_W-1:0]       data_i,
   input  logic [IF_W/8-1:0]     keep_i,
   output logic                  beat_done_o,
   output logic [DATA_W-1:0]     beat_data_o,
   output logic [DATA_W/8-1:0]   beat_keep_o
);

   localparam int unsigned SEGS  = rx_segs(DATA_W, IF_W);
   localparam int unsigned IDX_W = rx_seg_idx_w(SEGS);
   localparam int unsigned KW    = IF_W / 8;
   localparam int unsigned DKW   = DATA_W / 8;
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(SEGS - 1);
   localparam logic [IDX_W-1:0] ONE_LANE  = IDX_W'(1);

   logic [DATA_W-1:0] acc_data_q, acc_data_d;
   logic [DKW-1:0]    acc_keep_q, acc_keep_d;
   logic [IDX_W-1:0]  seg_idx_q, seg_idx_d;

   logic [IDX_W-1:0]  lane_s;
   logic [DATA_W-1:0] merged_data_s;
   logic [DKW-1:0]    merged_keep_s;
   logic              beat_done_s;

   // Merge the incoming segment into the accumulator image; a frame start restarts at lane 0 from a clean image
   always_comb begin
      lane_s        = start_i ? '0 : seg_idx_q;
      merged_data_s = start_i ? '0 : acc_data_q;
      merged_keep_s = start_i ? '0 : acc_keep_q;
      for (int l = 0; l < int'(SEGS); l++) begin
         if (wr_i && (lane_s == IDX_W'(l))) begin
            merged_data_s[l*IF_W +: IF_W] = data_i;
            merged_keep_s[l*KW +: KW]     = keep_i;
         end else begin
            merged_data_s[l*IF_W +: IF_W] = merged_data_s[l*IF_W +: IF_W];
            merged_keep_s[l*KW +: KW]     = merged_keep_s[l*KW +: KW];
         end
      end
      beat_done_s = wr_i && ((lane_s == LAST_LANE) || eop_i);
   end

   // Accumulator next state: cleared on flush or after a beat leaves, otherwise holds the merged image
   always_comb begin
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      seg_idx_d  = seg_idx_q;
      if (flush_i) begin
         acc_data_d = '0;
         acc_keep_d = '0;
         seg_idx_d  = '0;
      end else if (beat_done_s) begin
         acc_data_d = '0;
         acc_keep_d = '0;
         seg_idx_d  = '0;
      end else if (wr_i) begin
         acc_data_d = merged_data_s;
         acc_keep_d = merged_keep_s;
         seg_idx_d  = lane_s + ONE_LANE;
      end else begin
         acc_data_d = acc_data_q;
         acc_keep_d = acc_keep_q;
         seg_idx_d  = seg_idx_q;
      end
   end

   // Accumulator and lane counter registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_data_q <= '0;
         acc_keep_q <= '0;
         seg_idx_q  <= '0;
      end else begin
         acc_data_q <= acc_data_d;
         acc_keep_q <= acc_keep_d;
         seg_idx_q  <= seg_idx_d;
      end
   end

   assign beat_done_o = beat_done_s;
   assign beat_data_o = merged_data_s;
   assign beat_keep_o = merged_keep_s;

endmodule

// File: rtl/axi_bridge_ip_rx_deserializer.sv
// axi_bridge_ip_rx_deserializer: assembles IF_W-bit link segments into DATA_W-bit
// AXI beats and pushes packed {last, user, keep, data} words into the RX FIFO.
// Build option: define AXI_BRIDGE_RX_PROTO_CHECK_EN to drop non-sop segments in
// IDLE and to restart frames on an unexpected sop, with error pulses for both.
module axi_bridge_ip_rx_deserializer
   import axi_bridge_ip_rx_pkg::*;
#(
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned IF_W    = 64,
   parameter int unsigned TUSER_W = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  bridge_enable,
   input  logic                                  drop_on_midreset,
   input  logic                                  cl_rx_valid_i,
   output logic                                  cl_rx_ready_o,
   input  logic [IF_W-1:0]                       cl_rx_data_i,
   input  logic [IF_W/8-1:0]                     cl_rx_keep_i,
   input  logic [TUSER_W-1:0]                    cl_rx_user_i,
   input  logic                                  cl_rx_sop_i,
   input  logic                                  cl_rx_eop_i,
   input  logic                                  fifo_full_i,
   output logic                                  fifo_push_o,
   output logic [DATA_W+DATA_W/8+TUSER_W+1-1:0]  fifo_wdata_o,
   output logic                                  frame_done_pulse_o,
   output logic                                  stall_cycle_en_o,
   output logic                                  ev_err_midreset_drop_pulse_o,
   output logic                                  ev_err_no_sop_pulse_o,
   output logic                                  ev_err_sop_midframe_pulse_o
);

   localparam int unsigned DKW      = DATA_W / 8;
   localparam int unsigned WORD_W   = rx_word_w(DATA_W, TUSER_W);
   localparam int unsigned DATA_OFF = rx_data_off();
   localparam int unsigned KEEP_OFF = rx_keep_off(DATA_W);
   localparam int unsigned USER_OFF = rx_user_off(DATA_W);
   localparam int unsigned LAST_OFF = rx_last_off(DATA_W, TUSER_W);

   rx_state_e          state_q, state_d;
   logic               beat_full_q, beat_full_d;
   logic               bridge_enable_q;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [DKW-1:0]     out_keep_q, out_keep_d;
   logic [TUSER_W-1:0] out_user_q, out_user_d;
   logic               out_last_q, out_last_d;
   logic [TUSER_W-1:0] user_q, user_d;
   logic               midreset_pulse_q;
   logic               no_sop_pulse_q;
   logic               sop_mid_pulse_q;

   logic               ready_s;
   logic               accept_s;
   logic               midreset_det_s;
   logic               push_s;
   logic               start_s;
   logic               wr_s;
   logic               no_sop_s;
   logic               sop_mid_s;
   logic               beat_done_s;
   logic [DATA_W-1:0]  beat_data_s;
   logic [DKW-1:0]     beat_keep_s;
   logic [WORD_W-1:0]  wdata_s;

   assign ready_s  = bridge_enable && (!beat_full_q || !fifo_full_i);
   assign accept_s = cl_rx_valid_i && ready_s;

   // A partial frame or a held beat is dropped when the enable falls; this wins over a push
   assign midreset_det_s = drop_on_midreset && bridge_enable_q && !bridge_enable &&
                           ((state_q == RX_ACCUM) || beat_full_q);
   assign push_s = beat_full_q && !fifo_full_i && !midreset_det_s;

`ifdef AXI_BRIDGE_RX_PROTO_CHECK_EN
   // Only sop opens a frame; a sop inside a frame restarts it at that segment
   assign start_s   = accept_s && cl_rx_sop_i;
   assign no_sop_s  = accept_s && !cl_rx_sop_i && (state_q == RX_IDLE);
   assign sop_mid_s = accept_s && cl_rx_sop_i && (state_q == RX_ACCUM);
   assign wr_s      = accept_s && !no_sop_s;
`else
   // Any segment in IDLE opens a frame; sop inside a frame is plain data
   logic unused_sop_s;
   assign unused_sop_s = cl_rx_sop_i;
   assign start_s      = accept_s && (state_q == RX_IDLE);
   assign no_sop_s     = 1'b0;
   assign sop_mid_s    = 1'b0;
   assign wr_s         = accept_s;
`endif

   axi_bridge_ip_rx_des_beat_assemble #(
      .DATA_W (DATA_W),
      .IF_W   (IF_W)
   ) u_beat_assemble (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (midreset_det_s),
      .wr_i        (wr_s),
      .start_i     (start_s),
      .eop_i       (cl_rx_eop_i),
      .data_i      (cl_rx_data_i),
      .keep_i      (cl_rx_keep_i),
      .beat_done_o (beat_done_s),
      .beat_data_o (beat_data_s),
      .beat_keep_o (beat_keep_s)
   );

   // Frame FSM next state: eop closes the frame, any written segment otherwise keeps it open
   always_comb begin
      state_d = state_q;
      if (midreset_det_s) begin
         state_d = RX_IDLE;
      end else if (wr_s) begin
         state_d = cl_rx_eop_i ? RX_IDLE : RX_ACCUM;
      end else begin
         state_d = state_q;
      end
   end

   // Output beat register, full flag and frame user latch next state
   always_comb begin
      beat_full_d = beat_full_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_user_d  = out_user_q;
      out_last_d  = out_last_q;
      user_d      = user_q;
      if (start_s) begin
         user_d = cl_rx_user_i;
      end else begin
         user_d = user_q;
      end
      if (midreset_det_s) begin
         beat_full_d = 1'b0;
      end else if (beat_done_s) begin
         beat_full_d = 1'b1;
         out_data_d  = beat_data_s;
         out_keep_d  = beat_keep_s;
         out_user_d  = start_s ? cl_rx_user_i : user_q;
         out_last_d  = cl_rx_eop_i;
      end else if (push_s) begin
         beat_full_d = 1'b0;
      end else begin
         beat_full_d = beat_full_q;
      end
   end

   // State, output beat and enable history registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q         <= RX_IDLE;
         beat_full_q     <= 1'b0;
         bridge_enable_q <= 1'b0;
         out_data_q      <= '0;
         out_keep_q      <= '0;
         out_user_q      <= '0;
         out_last_q      <= 1'b0;
         user_q          <= '0;
      end else begin
         state_q         <= state_d;
         beat_full_q     <= beat_full_d;
         bridge_enable_q <= bridge_enable;
         out_data_q      <= out_data_d;
         out_keep_q      <= out_keep_d;
         out_user_q      <= out_user_d;
         out_last_q      <= out_last_d;
         user_q          <= user_d;
      end
   end

   // Event pulses, one cycle after the condition is seen
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         midreset_pulse_q <= 1'b0;
         no_sop_pulse_q   <= 1'b0;
         sop_mid_pulse_q  <= 1'b0;
      end else begin
         midreset_pulse_q <= midreset_det_s;
         no_sop_pulse_q   <= no_sop_s;
         sop_mid_pulse_q  <= sop_mid_s;
      end
   end

   // Pack the FIFO word using the shared field offsets
   always_comb begin
      wdata_s                          = '0;
      wdata_s[DATA_OFF +: DATA_W]      = out_data_q;
      wdata_s[KEEP_OFF +: DKW]         = out_keep_q;
      wdata_s[USER_OFF +: TUSER_W]     = out_user_q;
      wdata_s[LAST_OFF]                = out_last_q;
   end

   assign cl_rx_ready_o                = ready_s;
   assign fifo_push_o                  = push_s;
   assign fifo_wdata_o                 = wdata_s;
   assign frame_done_pulse_o           = push_s && out_last_q;
   assign stall_cycle_en_o             = cl_rx_valid_i && !ready_s;
   assign ev_err_midreset_drop_pulse_o = midreset_pulse_q;
   assign ev_err_no_sop_pulse_o        = no_sop_pulse_q;
   assign ev_err_sop_midframe_pulse_o  = sop_mid_pulse_q;

endmodule

// File: tb/tb_axi_bridge_ip_rx_deserializer.sv
// Scoreboard bench for axi_bridge_ip_rx_deserializer: frames are chunked into
// expected beats when issued; a monitor pops and compares on every FIFO push.
`timescale 1ns/1ps
module tb_axi_bridge_ip_rx_deserializer;

   localparam int DATA_W  = 256;
   localparam int IF_W    = 64;
   localparam int TUSER_W = 16;
   localparam int SEGS    = DATA_W / IF_W;
   localparam int KW      = IF_W / 8;
   localparam int DKW     = DATA_W / 8;
   localparam int WW      = DATA_W + DKW + TUSER_W + 1;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               bridge_enable = 1'b0;
   logic               drop_on_midreset = 1'b0;
   logic               valid = 1'b0;
   logic               sop = 1'b0;
   logic               eop = 1'b0;
   logic               fifo_full = 1'b0;
   logic [IF_W-1:0]    data = '0;
   logic [KW-1:0]      keep = '0;
   logic [TUSER_W-1:0] user = '0;

   logic               cl_rx_ready_o;
   logic               fifo_push_o;
   logic [WW-1:0]      fifo_wdata_o;
   logic               frame_done_pulse_o;
   logic               stall_cycle_en_o;
   logic               ev_err_midreset_drop_pulse_o;
   logic               ev_err_no_sop_pulse_o;
   logic               ev_err_sop_midframe_pulse_o;

   always #5 clk_i = ~clk_i;

   axi_bridge_ip_rx_deserializer #(
      .DATA_W (DATA_W), .IF_W (IF_W), .TUSER_W (TUSER_W)
   ) dut (
      .clk_i                        (clk_i),
      .rst_ni                       (rst_ni),
      .bridge_enable                (bridge_enable),
      .drop_on_midreset             (drop_on_midreset),
      .cl_rx_valid_i                (valid),
      .cl_rx_ready_o                (cl_rx_ready_o),
      .cl_rx_data_i                 (data),
      .cl_rx_keep_i                 (keep),
      .cl_rx_user_i                 (user),
      .cl_rx_sop_i                  (sop),
      .cl_rx_eop_i                  (eop),
      .fifo_full_i                  (fifo_full),
      .fifo_push_o                  (fifo_push_o),
      .fifo_wdata_o                 (fifo_wdata_o),
      .frame_done_pulse_o           (frame_done_pulse_o),
      .stall_cycle_en_o             (stall_cycle_en_o),
      .ev_err_midreset_drop_pulse_o (ev_err_midreset_drop_pulse_o),
      .ev_err_no_sop_pulse_o        (ev_err_no_sop_pulse_o),
      .ev_err_sop_midframe_pulse_o  (ev_err_sop_midframe_pulse_o)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] last_word = '0;
   int fd_cnt = 0, mr_cnt = 0, ns_cnt = 0, sm_cnt = 0, stall_cnt = 0;
   int frames_exp = 0;
   bit rand_full_en = 1'b0;

   logic [IF_W-1:0]    fd[$];
   logic [KW-1:0]      fk[$];
   logic [TUSER_W-1:0] fu;

   // Monitor: pop and compare on every push, count event pulses
   initial begin
      logic [WW-1:0] w;
      forever begin
         @(negedge clk_i);
         if (rst_ni) begin
            if (fifo_push_o) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_push got=%h", fifo_wdata_o);
               end else begin
                  w = exp_q.pop_front();
                  if (fifo_wdata_o !== w) begin
                     n_err++;
                     $display("FAIL beat got=%h exp=%h", fifo_wdata_o, w);
                  end
                  last_word = fifo_wdata_o;
                  n_cmp++;
                  if (frame_done_pulse_o !== w[WW-1]) begin
                     n_err++;
                     $display("FAIL frame_done got=%b exp=%b", frame_done_pulse_o, w[WW-1]);
                  end
               end
            end else if (frame_done_pulse_o) begin
               n_cmp++;
               n_err++;
               $display("FAIL frame_done_without_push got=1 exp=0");
            end
            if (frame_done_pulse_o)           fd_cnt++;
            if (ev_err_midreset_drop_pulse_o) mr_cnt++;
            if (ev_err_no_sop_pulse_o)        ns_cnt++;
            if (ev_err_sop_midframe_pulse_o)  sm_cnt++;
            if (stall_cycle_en_o)             stall_cnt++;
         end
      end
   end

   // Random FIFO backpressure, active only during the random phase
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (rand_full_en) fifo_full = ($urandom_range(0, 3) == 0);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic drive_seg(input logic [IF_W-1:0] d, input logic [KW-1:0] k,
                            input logic [TUSER_W-1:0] u, input bit s, input bit e);
      int waitc = 0;
      bit done = 1'b0;
      valid = 1'b1; data = d; keep = k; user = u; sop = s; eop = e;
      while (!done && waitc < 300) begin
         @(negedge clk_i);
         done = cl_rx_ready_o;
         @(posedge clk_i);
         #1;
         waitc++;
      end
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL seg_accept_timeout got=not_accepted exp=accepted");
      end
   endtask

   task automatic make_frame(input int n, input bit full_keep);
      fd.delete();
      fk.delete();
      fu = TUSER_W'($urandom);
      for (int i = 0; i < n; i++) begin
         fd.push_back({$urandom, $urandom});
         fk.push_back(full_keep ? 8'hFF : KW'($urandom_range(1, 255)));
      end
   endtask

   // Reference: split the frame into groups of SEGS segments, zero-pad, last on the final group
   task automatic expect_frame();
      int n = fd.size();
      int nb = (n + SEGS - 1) / SEGS;
      for (int b = 0; b < nb; b++) begin
         logic [DATA_W-1:0] bd;
         logic [DKW-1:0]    bk;
         bd = '0;
         bk = '0;
         for (int l = 0; l < SEGS; l++) begin
            if (b * SEGS + l < n) begin
               bd[l*IF_W +: IF_W] = fd[b*SEGS + l];
               bk[l*KW +: KW]     = fk[b*SEGS + l];
            end
         end
         exp_q.push_back({(b == nb - 1), fu, bk, bd});
      end
      frames_exp++;
   endtask

   task automatic send_frame(input bit with_sop, input int sop_at, input int gap_max);
      int n = fd.size();
      for (int i = 0; i < n; i++) begin
         drive_seg(fd[i], fk[i], (i == 0) ? fu : TUSER_W'($urandom),
                   (with_sop && i == 0) || (i == sop_at), i == n - 1);
         repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   task automatic drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 1000) begin
         tick();
         c++;
      end
      repeat (3) tick();
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      int b_fd, b_mr, b_ns, b_sm, b_st;
      // Reset state with enable low
      repeat (3) tick();
      chk("rst_ready", cl_rx_ready_o, 0);
      chk("rst_push", fifo_push_o, 0);
      chk("rst_wdata_zero", (fifo_wdata_o == '0) ? 1 : 0, 1);
      chk("rst_pulses", {ev_err_midreset_drop_pulse_o, ev_err_no_sop_pulse_o, ev_err_sop_midframe_pulse_o}, 0);
      rst_ni = 1'b1;
      bridge_enable = 1'b1;
      tick();

      // 8-segment frame, full keep: two beats, one frame_done
      b_fd = fd_cnt;
      make_frame(8, 1'b1); expect_frame(); send_frame(1'b1, -1, 0); drain();
      chk("frame8_done", fd_cnt - b_fd, 1);

      // 3-segment frame with eop keep 0x0F
      make_frame(3, 1'b1); fk[2] = 8'h0F; expect_frame(); send_frame(1'b1, -1, 0); drain();
      chk("frame3_keep", (last_word[DATA_W +: DKW] == 32'h000F_FFFF) ? 1 : 0, 1);
      chk("frame3_lane3_zero", (last_word[3*IF_W +: IF_W] == 64'd0) ? 1 : 0, 1);

      // Backpressure: FIFO full 5 cycles after beat 0 is pushed, valid held throughout
      b_st = stall_cnt;
      make_frame(8, 1'b1); expect_frame();
      fork
         begin
            send_frame(1'b1, -1, 0);
            make_frame(4, 1'b1); expect_frame(); send_frame(1'b1, -1, 0);
         end
         begin
            int c = 0;
            do begin @(negedge clk_i); c++; end while (!fifo_push_o && c < 100);
            @(posedge clk_i); #1; fifo_full = 1'b1;
            repeat (5) @(posedge clk_i);
            #1; fifo_full = 1'b0;
         end
      join
      drain();
      chk("bp_stall_cycles", stall_cnt - b_st, 2);

      // Midreset drop of a partial frame, then a clean frame
      b_mr = mr_cnt;
      drop_on_midreset = 1'b1;
      drive_seg({$urandom, $urandom}, 8'hFF, 16'h1234, 1'b1, 1'b0);
      drive_seg({$urandom, $urandom}, 8'hFF, 16'h5678, 1'b0, 1'b0);
      bridge_enable = 1'b0;
      repeat (3) tick();
      bridge_enable = 1'b1;
      tick();
      make_frame(5, 1'b0); expect_frame(); send_frame(1'b1, -1, 0); drain();
      chk("midreset_partial_pulses", mr_cnt - b_mr, 1);

      // Midreset drop of a beat held by a full FIFO
      b_mr = mr_cnt;
      fifo_full = 1'b1;
      make_frame(4, 1'b1); send_frame(1'b1, -1, 0);
      bridge_enable = 1'b0;
      repeat (2) tick();
      fifo_full = 1'b0;
      repeat (3) tick();
      bridge_enable = 1'b1;
      drop_on_midreset = 1'b0;
      tick();
      chk("midreset_held_pulses", mr_cnt - b_mr, 1);

      // Enable falls without drop: the held beat still drains
      b_mr = mr_cnt;
      fifo_full = 1'b1;
      make_frame(4, 1'b1); expect_frame(); send_frame(1'b1, -1, 0);
      bridge_enable = 1'b0;
      repeat (2) tick();
      fifo_full = 1'b0;
      drain();
      bridge_enable = 1'b1;
      tick();
      chk("nodrop_pulses", mr_cnt - b_mr, 0);

      b_ns = ns_cnt; b_sm = sm_cnt;
`ifdef AXI_BRIDGE_RX_PROTO_CHECK_EN
      // Non-sop segment in IDLE is dropped and flagged
      drive_seg({$urandom, $urandom}, 8'hFF, 16'hAAAA, 1'b0, 1'b0);
      repeat (3) tick();
      chk("no_sop_pulses", ns_cnt - b_ns, 1);
      // sop after two segments restarts the frame
      drive_seg({$urandom, $urandom}, 8'hFF, 16'hBBBB, 1'b1, 1'b0);
      drive_seg({$urandom, $urandom}, 8'hFF, 16'hCCCC, 1'b0, 1'b0);
      make_frame(5, 1'b0); expect_frame(); send_frame(1'b1, -1, 0); drain();
      chk("sop_mid_pulses", sm_cnt - b_sm, 1);
`else
      // Frame without sop opens in IDLE; a later sop is ordinary data
      make_frame(5, 1'b0); expect_frame(); send_frame(1'b0, -1, 0); drain();
      make_frame(6, 1'b0); expect_frame(); send_frame(1'b1, 2, 0); drain();
      chk("no_sop_pulses", ns_cnt - b_ns, 0);
      chk("sop_mid_pulses", sm_cnt - b_sm, 0);
`endif

      // Reset mid-frame: outputs cleared, next frame starts at lane 0
      b_mr = mr_cnt; b_fd = fd_cnt;
      drive_seg({$urandom, $urandom}, 8'hFF, 16'h0F0F, 1'b1, 1'b0);
      drive_seg({$urandom, $urandom}, 8'hFF, 16'hF0F0, 1'b0, 1'b0);
      rst_ni = 1'b0;
      tick();
      chk("midrst_push", fifo_push_o, 0);
      chk("midrst_done", frame_done_pulse_o, 0);
      chk("midrst_wdata_zero", (fifo_wdata_o == '0) ? 1 : 0, 1);
      chk("midrst_pulses", {ev_err_midreset_drop_pulse_o, ev_err_no_sop_pulse_o, ev_err_sop_midframe_pulse_o}, 0);
      rst_ni = 1'b1;
      tick();
      make_frame(3, 1'b0); expect_frame(); send_frame(1'b1, -1, 0); drain();
      chk("midrst_no_drop_pulse", mr_cnt - b_mr, 0);
      chk("midrst_frame_done", fd_cnt - b_fd, 1);

      // Random frames with random gaps and random FIFO backpressure
      rand_full_en = 1'b1;
      for (int f = 0; f < 25; f++) begin
         make_frame($urandom_range(1, 11), 1'b0);
         expect_frame();
         send_frame(1'b1, -1, 2);
      end
      rand_full_en = 1'b0;
      tick();
      fifo_full = 1'b0;
      drain();
      chk("total_frames", fd_cnt, frames_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_bridge_ip_rx_deserializer.md
# axi_bridge_ip_rx_deserializer

Receive-side counterpart of the AXI bridge TX serializer. Accepts narrow IF_W-bit link segments with sop/eop/keep/user framing from the link layer, assembles them into DATA_W-bit AXI beats, and pushes each packed beat word into the RX FIFO. It handles FIFO backpressure, a controlled mid-frame drop when the bridge is disabled, and frame/stall/error pulses for the stats and event logic.

## Interface
- DATA_W, 256, AXI beat width; integer multiple of IF_W
- IF_W, 64, link segment width
- TUSER_W, 16, sideband user width
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- bridge_enable  in  1  CSR enable
- drop_on_midreset  in  1  CSR: discard the partial frame when enable falls mid-frame
- cl_rx_valid_i / cl_rx_ready_o  in/out  1  segment handshake
- cl_rx_data_i  in  IF_W  segment data
- cl_rx_keep_i  in  IF_W/8  byte enables
- cl_rx_user_i  in  TUSER_W  user, sampled on the sop segment
- cl_rx_sop_i / cl_rx_eop_i  in  1  frame delimiters
- fifo_full_i  in  1  RX FIFO full
- fifo_push_o  out  1  write strobe
- fifo_wdata_o  out  DATA_W+DATA_W/8+TUSER_W+1  packed word {last, user, keep, data}, data at LSB
- frame_done_pulse_o  out  1  one cycle with the push of a last=1 beat
- stall_cycle_en_o  out  1  cl_rx_valid_i && !cl_rx_ready_o
- ev_err_midreset_drop_pulse_o  out  1  partial frame discarded
- ev_err_no_sop_pulse_o / ev_err_sop_midframe_pulse_o  out  1  protocol errors (see Configuration)

## Operation
- SEGS = DATA_W/IF_W. A lane counter seg_idx (width clog2(SEGS), minimum 1) indexes the accumulator lane.
- States:
  - IDLE: waiting for sop.
  - ACCUM: inside a frame.
- Acceptance: a segment is accepted when valid && ready. cl_rx_ready_o = bridge_enable && (!beat_full || !fifo_full_i).
- Accepted segment handling:
  - Data is written to lane seg_idx; keep goes to keep bits [seg_idx*IF_W/8 +: IF_W/8].
  - On sop, user is latched, the accumulator keep is cleared, seg_idx is set to 0, and the state moves to ACCUM.
- Beat completion: occurs when seg_idx==SEGS-1 or eop. On completion:
  - The accumulator moves to the output register and beat_full is set; last=eop.
  - Unfilled lanes carry keep=0 and data=0.
  - seg_idx returns to 0.
  - eop returns the state to IDLE.
- Output: fifo_push_o = beat_full && !fifo_full_i. beat_full clears on push unless a new beat completes in the same cycle.
- Output beat user is the frame's sop user on every beat of the frame.
- Midreset drop: bridge_enable_q is the registered enable. When drop_on_midreset && bridge_enable_q && !bridge_enable && (state==ACCUM || beat_full), at the next edge:
  - The accumulator, seg_idx and beat_full are cleared, and the state goes to IDLE.
  - ev_err_midreset_drop_pulse_o is high for exactly one cycle.
  - No push occurs in that detection cycle.
- Enable falls with drop_on_midreset=0: ready goes low, and a held beat still drains to the FIFO.

## Timing
- Reset (rst_ni low at an edge): all outputs 0, state IDLE, seg_idx 0, beat_full 0, bridge_enable_q 0. cl_rx_ready_o is also 0 while enable is 0.
- Latency: fifo_push_o rises one cycle after the completing segment is accepted, when the FIFO is not full.
- Throughput: one segment per cycle with the FIFO not full; no bubble at beat boundaries.
- Backpressure: fifo_full_i holds beat_full. Ready stays high until the next beat completes, then drops until a push occurs.
- eop on the SEGS-1 lane produces exactly one beat. sop and eop on the same segment produce a single-beat frame.
- Midreset detection takes priority over a push in the same cycle.
- rst_ni asserted mid-frame discards all state; no pulses are emitted.

## Configuration
- AXI_BRIDGE_RX_PROTO_CHECK_EN defined:
  - A segment without sop in IDLE is consumed (ready high) and dropped, and ev_err_no_sop_pulse_o is pulsed next cycle.
  - sop in ACCUM discards the partial accumulator, restarts the frame at that segment, and pulses ev_err_sop_midframe_pulse_o. Beats already pushed are unaffected.
- Not defined:
  - A non-sop segment in IDLE starts a frame with user taken from that segment.
  - sop in ACCUM is treated as ordinary data.
  - Both error outputs are tied 0.

## Structure
- Package axi_bridge_ip_rx_pkg holds:
  - the state enum;
  - SEGS and width functions for seg_idx and the FIFO word;
  - field offsets of the packed FIFO word, shared with the RX FIFO and AXI master logic.
- Sub-module axi_bridge_ip_rx_des_beat_assemble holds the accumulator, lane write and seg_idx. The top level holds the FSM, output register, midreset logic and pulses.

## Test plan
All cases use DATA_W=256 and IF_W=64.
- 8-segment frame, keep 0xFF on each, FIFO never full → 2 pushes. Beat 0 has last=0 and keep=32'hFFFF_FFFF; beat 1 has last=1. frame_done pulses once.
- 3-segment frame, eop keep 0x0F → 1 push with keep=32'h000F_FFFF and last=1. Lane 3 data is 0.
- fifo_full_i high for 5 cycles after beat 0 completes while valid is held → ready drops once beat 1 completes, stall_cycle_en high for those cycles. Both beats arrive intact, in order.
- drop_on_midreset=1, bridge_enable falls after 2 segments → no push, one ev_err_midreset_drop pulse. The next frame after re-enable is correct.
- PROTO_CHECK_EN: non-sop segment in IDLE → no push, one ev_err_no_sop pulse. sop after 2 segments → one ev_err_sop_midframe pulse; the new frame is correct.
- rst_ni low for 1 cycle mid-frame → all outputs 0. The next frame assembles from lane 0.
